branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Fetch-side producer of the predicted next PC that the ID/EX latch carries forward as predicted_pc_in.
- Execute-side consumer of the resolved branch outcome (inst_pc_ex, predicted_pc_out, resolved target and direction).
- Direct-mapped BTB with 2-bit saturating direction counters.
- Flags a mispredict and supplies the correct PC so the datapath can flush IF/ID and ID/EX.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..256.
- IDX_W, $clog2(ENTRIES), index width; derived, never overridden.
- CNT_W, 32, width of each performance counter.

Ports:
- CLK  input  1  core clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- lookup_pc  input  32  PC being fetched this cycle.
- predicted_pc  output  32  predicted next PC; goes to the PC register and to predicted_pc_in.
- pred_taken  output  1  1 = BTB hit with taken prediction.
- resolve_valid  input  1  EX stage holds a resolved branch/jump this cycle; already gated by bubble/flush.
- resolve_pc  input  32  PC of the resolving instruction (inst_pc_ex).
- resolve_taken  input  1  actual direction; 1 for all jumps.
- resolve_target  input  32  actual taken target.
- resolve_predicted  input  32  PC predicted at fetch for this instruction (predicted_pc_out).
- mispredict  output  1  actual next PC differs from the predicted PC.
- correct_pc  output  32  actual next PC of the resolving instruction.
- branch_cnt  output  CNT_W  number of resolved branches.
- mispred_cnt  output  CNT_W  number of mispredicts.

Behaviour:
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:2], ctr[1:0]. Index = pc[IDX_W+1:2].
- Reset (async, nRST=0), all cleared immediately, including mid-update:
  - every valid=0, every ctr=2'b01;
  - branch_cnt=0, mispred_cnt=0.
- Post-reset outputs with resolve_valid=0: pred_taken=0, predicted_pc=lookup_pc+4, mispredict=0.
- Lookup is combinational from registered table state, zero latency:
  - hit = valid[idx] && tag match;
  - pred_taken = hit && ctr[1];
  - predicted_pc = pred_taken ? {target,2'b00} : lookup_pc+4, with 32-bit wrap (0xFFFFFFFC+4 = 0).
- Resolution is combinational, same cycle:
  - actual = resolve_taken ? resolve_target : resolve_pc+4;
  - mispredict = resolve_valid && (actual != resolve_predicted);
  - correct_pc = actual, driven even when resolve_valid=0 (don't-care).
- Table update at the rising edge when resolve_valid=1, indexed by resolve_pc:
  - hit, taken: ctr saturating increment (max 3); target overwritten with resolve_target.
  - hit, not taken: ctr saturating decrement (min 0); target kept.
  - miss, taken: allocate by overwriting the slot; valid=1, tag, target set, ctr=2'b10.
  - miss, not taken: no change.
  - resolve_valid=0: table unchanged.
- Same-cycle lookup and update to the same index: lookup sees the pre-edge contents; no bypass.
- Counters, at the edge:
  - branch_cnt += 1 when resolve_valid=1;
  - mispred_cnt += 1 when mispredict=1;
  - both saturate at all-ones, no wrap.
- No stall input: the caller holds resolve_valid low during stalls so the same instruction is not counted twice.

Decomposition:
- cpu_types_pkg gains:
  - BTB_ENTRIES constant;
  - btb_entry_t packed struct {valid, tag, target, ctr};
  - btb_ctr_t typedef logic[1:0], with constants STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3.
- One sub-module, sat_ctr2: combinational next-state of a 2-bit saturating counter from (ctr, taken).

Test Plan:
- Reset, then lookup_pc=0x0000_0040 → pred_taken=0, predicted_pc=0x0000_0044. Also pull nRST low mid-update → all entries invalid and counters zero immediately.
- Resolve pc=0x40, taken, target=0x100, predicted=0x44 → mispredict=1, correct_pc=0x100. Next cycle lookup 0x40 → pred_taken=1, predicted_pc=0x100; entry ctr=2.
- Same branch resolved not-taken twice, each with the correct predicted value:
  - first: predicted=0x100 → mispredict=1, correct_pc=0x44, ctr becomes 1, lookup 0x40 → 0x44;
  - second: predicted=0x44 → mispredict=0, ctr becomes 0.
- Aliasing, ENTRIES=16: resolve 0x40 taken to 0x100, then 0x80 taken to 0x200 (same index 0) → lookup 0x40 misses (0x44), lookup 0x80 hits (0x200).
- Same-index collision: resolve 0x40 taken while lookup_pc=0x40 in the same cycle → that cycle predicted_pc=0x44; the following cycle 0x100.
- Counter checks:
  - 10 resolves with 3 mispredicts → branch_cnt=10, mispred_cnt=3;
  - preload branch_cnt to 0xFFFFFFFF (force) and resolve once → stays 0xFFFFFFFF;
  - lookup_pc=0xFFFFFFFC on a miss → predicted_pc=0x0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch target buffer entry layout and 2-bit direction counter encoding.
package cpu_types_pkg;

    localparam int BTB_ENTRIES = 16;

    typedef logic [1:0] btb_ctr_t;

    localparam btb_ctr_t STRONG_NT = 2'd0;
    localparam btb_ctr_t WEAK_NT   = 2'd1;
    localparam btb_ctr_t WEAK_T    = 2'd2;
    localparam btb_ctr_t STRONG_T  = 2'd3;

    // Tag is sized for the smallest index width and zero-extended for larger tables.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        btb_ctr_t    ctr;
    } btb_entry_t;

    function automatic logic [29:0] btb_tag(input logic [31:0] pc, input int idx_w);
        return pc[31:2] >> idx_w;
    endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Next state of a 2-bit saturating direction counter.
module sat_ctr2
    import cpu_types_pkg::*;
(
    input  btb_ctr_t ctr,
    input  logic     taken,
    output btb_ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != STRONG_T) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != STRONG_NT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency fetch prediction, same-cycle mispredict detection,
// table update and performance counting at the clock edge.
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter  int ENTRIES = BTB_ENTRIES,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      lookup_pc,
    output logic [31:0]      predicted_pc,
    output logic             pred_taken,
    input  logic             resolve_valid,
    input  logic [31:0]      resolve_pc,
    input  logic             resolve_taken,
    input  logic [31:0]      resolve_target,
    input  logic [31:0]      resolve_predicted,
    output logic             mispredict,
    output logic [31:0]      correct_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam btb_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};

    btb_entry_t            entry_rd [ENTRIES];
    logic [IDX_W-1:0]      lk_idx;
    logic [IDX_W-1:0]      upd_idx;
    btb_entry_t            lk_entry;
    btb_entry_t            upd_entry;
    btb_entry_t            entry_next;
    logic                  lk_hit;
    logic                  upd_hit;
    logic                  upd_en;
    btb_ctr_t              ctr_sat;
    logic [31:0]           actual_pc;
    logic [CNT_W-1:0]      branch_cnt_reg;
    logic [CNT_W-1:0]      mispred_cnt_reg;

    assign lk_idx   = lookup_pc[IDX_W+1:2];
    assign upd_idx  = resolve_pc[IDX_W+1:2];
    assign lk_entry = entry_rd[lk_idx];
    assign upd_entry = entry_rd[upd_idx];

    // Lookup reads only registered state, so a same-edge update is not visible here.
    assign lk_hit       = lk_entry.valid && (lk_entry.tag == btb_tag(lookup_pc, IDX_W));
    assign pred_taken   = lk_hit && lk_entry.ctr[1];
    assign predicted_pc = pred_taken ? {lk_entry.target, 2'b00} : lookup_pc + 32'd4;

    assign actual_pc  = resolve_taken ? resolve_target : resolve_pc + 32'd4;
    assign correct_pc = actual_pc;
    assign mispredict = resolve_valid && (actual_pc != resolve_predicted);

    assign upd_hit = upd_entry.valid && (upd_entry.tag == btb_tag(resolve_pc, IDX_W));

    sat_ctr2 u_sat_ctr2 (
        .ctr      (upd_entry.ctr),
        .taken    (resolve_taken),
        .ctr_next (ctr_sat)
    );

    always_comb begin
        entry_next = upd_entry;
        upd_en     = 1'b0;
        if (resolve_valid) begin
            if (upd_hit) begin
                upd_en         = 1'b1;
                entry_next.ctr = ctr_sat;
                if (resolve_taken) entry_next.target = resolve_target[31:2];
            end else if (resolve_taken) begin
                upd_en     = 1'b1;
                entry_next = '{valid: 1'b1, tag: btb_tag(resolve_pc, IDX_W),
                               target: resolve_target[31:2], ctr: WEAK_T};
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            btb_entry_t entry_reg;

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    entry_reg <= ENTRY_RESET;
                end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
                    entry_reg <= entry_next;
                end
            end

            assign entry_rd[gi] = entry_reg;
        end
    endgenerate

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (resolve_valid && (branch_cnt_reg != '1))
                branch_cnt_reg <= branch_cnt_reg + 1'b1;
            if (mispredict && (mispred_cnt_reg != '1))
                mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
        end
    end

    assign branch_cnt  = branch_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed table-driven bench for branch_target_buffer plus reset/counter sequences.
module tb_branch_target_buffer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] lookup_pc;
    logic [31:0] predicted_pc;
    logic        pred_taken;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic [31:0] resolve_predicted;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    branch_target_buffer #(.ENTRIES(16), .CNT_W(32)) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .lookup_pc         (lookup_pc),
        .predicted_pc      (predicted_pc),
        .pred_taken        (pred_taken),
        .resolve_valid     (resolve_valid),
        .resolve_pc        (resolve_pc),
        .resolve_taken     (resolve_taken),
        .resolve_target    (resolve_target),
        .resolve_predicted (resolve_predicted),
        .mispredict        (mispredict),
        .correct_pc        (correct_pc),
        .branch_cnt        (branch_cnt),
        .mispred_cnt       (mispred_cnt)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rtk;
        logic [31:0] rtgt;
        logic [31:0] rpred;
        logic [31:0] lpc;
        logic        e_mis;
        logic [31:0] e_cpc;
        logic        e_pt;
        logic [31:0] e_ppc;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rtk,
                         input logic [31:0] rtgt, input logic [31:0] rpred, input logic [31:0] lpc);
        resolve_valid     = rv;
        resolve_pc        = rpc;
        resolve_taken     = rtk;
        resolve_target    = rtgt;
        resolve_predicted = rpred;
        lookup_pc         = lpc;
    endtask

    initial begin
        //          rv    rpc           tk    tgt           pred          lookup        mis   cpc           pt    ppc
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        32'h40,       1'b0, 32'h4,        1'b0, 32'h44};
        vecs[1]  = '{1'b1, 32'h40,       1'b1, 32'h100,      32'h44,       32'h40,       1'b1, 32'h100,      1'b0, 32'h44};
        vecs[2]  = '{1'b0, 32'h40,       1'b0, 32'h0,        32'h44,       32'h40,       1'b0, 32'h44,       1'b1, 32'h100};
        vecs[3]  = '{1'b1, 32'h40,       1'b0, 32'h0,        32'h100,      32'h40,       1'b1, 32'h44,       1'b1, 32'h100};
        vecs[4]  = '{1'b1, 32'h40,       1'b0, 32'h0,        32'h44,       32'h40,       1'b0, 32'h44,       1'b0, 32'h44};
        vecs[5]  = '{1'b1, 32'h40,       1'b1, 32'h100,      32'h44,       32'h40,       1'b1, 32'h100,      1'b0, 32'h44};
        vecs[6]  = '{1'b0, 32'h40,       1'b0, 32'h0,        32'h44,       32'h40,       1'b0, 32'h44,       1'b0, 32'h44};
        vecs[7]  = '{1'b1, 32'h80,       1'b1, 32'h200,      32'h84,       32'h80,       1'b1, 32'h200,      1'b0, 32'h84};
        vecs[8]  = '{1'b0, 32'h80,       1'b0, 32'h0,        32'h84,       32'h40,       1'b0, 32'h84,       1'b0, 32'h44};
        vecs[9]  = '{1'b0, 32'h80,       1'b0, 32'h0,        32'h84,       32'h80,       1'b0, 32'h84,       1'b1, 32'h200};
        vecs[10] = '{1'b1, 32'h80,       1'b1, 32'h300,      32'h200,      32'h80,       1'b1, 32'h300,      1'b1, 32'h200};
        vecs[11] = '{1'b1, 32'h80,       1'b0, 32'h0,        32'h300,      32'hFFFFFFFC, 1'b1, 32'h84,       1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h80,       1'b0, 32'h0,        32'h84,       32'h80,       1'b0, 32'h84,       1'b1, 32'h300};
        vecs[13] = '{1'b1, 32'h44,       1'b0, 32'h0,        32'h48,       32'h44,       1'b0, 32'h48,       1'b0, 32'h48};
        vecs[14] = '{1'b0, 32'h44,       1'b0, 32'h0,        32'h48,       32'h44,       1'b0, 32'h48,       1'b0, 32'h48};
        vecs[15] = '{1'b0, 32'h10,       1'b1, 32'h500,      32'h0,        32'h80,       1'b0, 32'h500,      1'b1, 32'h300};
        vecs[16] = '{1'b0, 32'h10,       1'b0, 32'h0,        32'h14,       32'h10,       1'b0, 32'h14,       1'b0, 32'h14};

        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h40);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("reset_branch_cnt", branch_cnt, 32'h0);
        check("reset_mispred_cnt", mispred_cnt, 32'h0);
        check("reset_mispredict", {31'b0, mispredict}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            @(negedge CLK);
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].rtk, vecs[i].rtgt, vecs[i].rpred, vecs[i].lpc);
            #1;
            check($sformatf("v%0d_mispredict", i), {31'b0, mispredict}, {31'b0, vecs[i].e_mis});
            check($sformatf("v%0d_correct_pc", i), correct_pc, vecs[i].e_cpc);
            check($sformatf("v%0d_pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
            check($sformatf("v%0d_predicted_pc", i), predicted_pc, vecs[i].e_ppc);
            $display("vec %0d rv=%0b rpc=%h lpc=%h mis=%0b cpc=%h pt=%0b ppc=%h",
                     i, resolve_valid, resolve_pc, lookup_pc, mispredict, correct_pc, pred_taken, predicted_pc);
        end
        check("table_branch_cnt", branch_cnt, 32'd8);
        check("table_mispred_cnt", mispred_cnt, 32'd6);

        // Reset asserted while an update is pending must clear state without a clock edge.
        @(negedge CLK);
        drive(1'b1, 32'h80, 1'b1, 32'h400, 32'h0, 32'h80);
        #2 nRST = 1'b0;
        #1;
        check("midrst_branch_cnt", branch_cnt, 32'h0);
        check("midrst_mispred_cnt", mispred_cnt, 32'h0);
        check("midrst_pred_taken", {31'b0, pred_taken}, 32'h0);
        check("midrst_predicted_pc", predicted_pc, 32'h84);
        $display("midreset branch_cnt=%h mispred_cnt=%h ppc=%h", branch_cnt, mispred_cnt, predicted_pc);
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h80);
        nRST = 1'b1;
        #1;
        check("postrst_predicted_pc", predicted_pc, 32'h84);

        // Ten not-taken resolves, three with a wrong prediction.
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            drive(1'b1, 32'h400, 1'b0, 32'h0,
                  (i == 2 || i == 5 || i == 7) ? 32'h0 : 32'h404, 32'h80);
            $display("cnt resolve %0d pred=%h mis=%0b", i, resolve_predicted, mispredict);
        end
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h400);
        #1;
        check("cnt10_branch_cnt", branch_cnt, 32'd10);
        check("cnt10_mispred_cnt", mispred_cnt, 32'd3);
        check("cnt10_nt_no_alloc", predicted_pc, 32'h404);

        // Saturation of the branch counter.
        force dut.branch_cnt_reg = 32'hFFFFFFFF;
        @(negedge CLK);
        release dut.branch_cnt_reg;
        drive(1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 32'h400);
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h400);
        #1;
        check("sat_branch_cnt", branch_cnt, 32'hFFFFFFFF);
        check("sat_mispred_cnt", mispred_cnt, 32'd4);
        $display("saturate branch_cnt=%h mispred_cnt=%h", branch_cnt, mispred_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
